muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide/accumulate unit used by the execute stage for HI/LO-writing and MUL-class instructions. It replaces the separate mult/div instances with one engine that has the following capabilities:
- signed and unsigned modes
- MADD/MSUB accumulate into a supplied HI:LO
- configurable multiply latency
- flush/abort
- defined divide-by-zero results
Execute holds the request until done and uses the stall output to freeze the front of the pipeline.

Parameters:
WIDTH, 32, operand width; results are two WIDTH-bit halves.
MUL_LAT, 3, cycles from request acceptance to done for multiply-class ops; legal range 2..8.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req  in  1  operation request; held high by execute until done
flush  in  1  abort current operation (exception/redirect)
op  in  4  muldiv_op_t: MULT, MULTU, MUL, MADD, MADDU, MSUB, MSUBU, DIV, DIVU
a  in  WIDTH  operand A (rs)
b  in  WIDTH  operand B (rt)
acc_hi  in  WIDTH  current HI for MADD/MSUB
acc_lo  in  WIDTH  current LO for MADD/MSUB
busy  out  1  unit not in IDLE
stall  out  1  req & ~done & ~flush, combinational
done  out  1  one-cycle pulse, result valid
hi  out  WIDTH  result high half / remainder
lo  out  WIDTH  result low half / quotient

Behaviour:
Reset:
- Asynchronous. state=IDLE; busy=0, done=0, hi=0, lo=0; counters cleared.
- Reset mid-operation discards the operation silently.

State machine (IDLE, MUL, DIV, FIX, DONE):
- IDLE: if req & ~flush, latch op, a, b, acc_hi, acc_lo; go to DIV for DIV/DIVU, MUL otherwise.
- MUL: operate on absolute values. Count MUL_LAT-2 cycles, then go to FIX.
- DIV: radix-2 restoring, one quotient bit per cycle, WIDTH cycles, then FIX.
  - If the latched b==0, skip iterations and go directly to FIX.
- FIX: sign correction and accumulate; register hi/lo; go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
  - req is ignored in DONE. The pipeline advances at the end of the DONE cycle, so req seen in IDLE afterwards belongs to the next instruction.

Latency (cycle 0 = IDLE cycle with req accepted):
- done high in cycle MUL_LAT for multiply-class ops.
- done high in cycle WIDTH+2 for divide.
- done high in cycle 2 for divide by zero.
- Back-to-back requests: the next op is accepted in the cycle after DONE.

Flush:
- In any state except DONE, flush forces IDLE on the next edge; no done pulse; hi/lo unchanged.
- flush in DONE has no effect; the result is already presented.
- flush together with req in IDLE: not accepted.

Arithmetic:
- MULT/MADD/MSUB/MUL: signed product = sign(a^b) applied to |a|*|b| (2*WIDTH bits).
- MULTU/MADDU/MSUBU: unsigned product.
- MADD*: {hi,lo} = {acc_hi,acc_lo} + product.
- MSUB*: {hi,lo} = {acc_hi,acc_lo} - product. Modulo 2^(2*WIDTH); no overflow flag.
- MUL: lo = product[WIDTH-1:0]; hi = product[2*WIDTH-1:WIDTH]. Execute writes only lo to the GPR.
- DIV: quotient sign = sign(a^b); remainder sign = sign(a). MIN / -1 gives lo=MIN, hi=0.
- Divide by zero (both signednesses): lo = all ones, hi = a.

Outputs:
- hi/lo hold their value until the next done.
- busy = (state != IDLE).

Decomposition:
- Shared package additions: muldiv_op_t enum (4-bit), muldiv_state_t enum, per-op helper predicates is_signed and is_div.
- Natural sub-module: muldiv_divider (iterative restoring core with start/abort/count/done). The multiply path stays inline as a registered product plus delay shift register.

Test Plan:
1. MULT a=0xFFFFFFFD (-3), b=7 -> done in cycle 3; hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall high in cycles 0-2, low in 3.
2. DIV a=0xFFFFFFF9 (-7), b=2 -> done in cycle 34; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
3. DIVU a=0x80000000, b=0 -> done in cycle 2; lo=0xFFFFFFFF, hi=0x80000000.
4. Accumulate and MUL:
   - MADD acc_hi=0, acc_lo=0xFFFFFFFF, a=1, b=1 -> hi=1, lo=0.
   - MSUBU acc=0, a=1, b=1 -> hi=lo=0xFFFFFFFF.
   - MUL a=0x10000, b=0x10000 -> lo=0, hi=1.
5. DIVU in progress, flush in cycle 10 -> no done; busy=0 in cycle 11; hi/lo unchanged. MULTU 0xFFFFFFFF*2 requested in cycle 11 -> done in cycle 14 with hi=1, lo=0xFFFFFFFE.
6. Back-to-back with req held through DONE: second MULT accepted in the cycle after DONE, exactly one done per op. resetn low in cycle 5 of a DIV -> busy=done=hi=lo=0 immediately, no done after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state types and op-class predicates for the multiply/divide unit
package muldiv_pkg;
  typedef enum logic [3:0] {
    OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU
  } muldiv_op_t;
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} muldiv_state_t;
  function automatic logic is_signed(input muldiv_op_t op);
    return op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB, OP_DIV};
  endfunction
  function automatic logic is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction
  function automatic logic is_madd(input muldiv_op_t op);
    return op inside {OP_MADD, OP_MADDU};
  endfunction
  function automatic logic is_msub(input muldiv_op_t op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction
endpackage

// File: rtl/muldiv_divider.sv
// muldiv_divider: iterative radix-2 restoring divider on unsigned magnitudes
module muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt;
  logic [WIDTH:0] trial;
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};
  assign last = cnt == CW'(1);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      quo <= '0;
      rem <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
      quo <= dividend;
      rem <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle signed/unsigned multiply, multiply-accumulate and divide engine
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic             flush,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [2:0] MC = 3'(MUL_LAT > 2 ? MUL_LAT - 3 : 0);
  muldiv_state_t state, state_n;
  muldiv_op_t op_q;
  logic [2:0] cnt;
  logic neg_q, rneg_q, dz_q, accept, last, sa;
  logic [WIDTH-1:0] a_q, abs_a, abs_b, quo, rem, quo_s, rem_s;
  logic [2*WIDTH-1:0] acc_q, prod_q, prod_s, res;
  assign sa = is_signed(op);
  assign abs_a = (sa && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sa && b[WIDTH-1]) ? -b : b;
  assign accept = state == S_IDLE && req && !flush;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign stall = req & ~done & ~flush;
  muldiv_divider #(.WIDTH(WIDTH)) u_div (
    .clk     (clk),
    .resetn  (resetn),
    .start   (accept && is_div(op) && b != '0),
    .abort   (flush),
    .dividend(abs_a),
    .divisor (abs_b),
    .last    (last),
    .quo     (quo),
    .rem     (rem)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept) state_n = is_div(op) ? (b == '0 ? S_FIX : S_DIV) : (MUL_LAT == 2 ? S_FIX : S_MUL);
      S_MUL:  if (cnt == MC) state_n = S_FIX;
      S_DIV:  if (last) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush && state != S_DONE) state_n = S_IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else state <= state_n;
  end
  assign prod_s = neg_q ? -prod_q : prod_q;
  assign quo_s = neg_q ? -quo : quo;
  assign rem_s = rneg_q ? -rem : rem;
  assign res = is_div(op_q) ? (dz_q ? {a_q, {WIDTH{1'b1}}} : {rem_s, quo_s})
             : is_madd(op_q) ? acc_q + prod_s
             : is_msub(op_q) ? acc_q - prod_s
             : prod_s;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= OP_MULT;
      a_q    <= '0;
      acc_q  <= '0;
      prod_q <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (accept) begin
        op_q   <= op;
        a_q    <= a;
        acc_q  <= {acc_hi, acc_lo};
        prod_q <= {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
        neg_q  <= sa & (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg_q <= sa & a[WIDTH-1];
        dz_q   <= b == '0;
      end
      cnt <= (accept || flush) ? 3'd0 : state == S_MUL ? cnt + 3'd1 : cnt;
      if (state == S_FIX && !flush) {hi, lo} <= res;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for latency, arithmetic, flush and reset behaviour
module tb_muldiv_unit;
  import muldiv_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0, resetn = 1'b0, req = 1'b0, flush = 1'b0;
  muldiv_op_t op = OP_MULT;
  logic [W-1:0] a = '0, b = '0, acc_hi = '0, acc_lo = '0;
  logic busy, stall, done;
  logic [W-1:0] hi, lo;
  int checks = 0, errors = 0, ndone = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] sb_exp;
  logic stall_log[0:63];
  muldiv_unit #(.WIDTH(W), .MUL_LAT(3)) dut (
    .clk(clk), .resetn(resetn), .req(req), .flush(flush), .op(op), .a(a), .b(b),
    .acc_hi(acc_hi), .acc_lo(acc_lo), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (resetn && done) begin
      ndone++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done got hi=%h lo=%h with no result pending", hi, lo);
      end else begin
        sb_exp = sb.pop_front();
        if ({hi, lo} !== sb_exp) begin
          errors++;
          $display("FAIL sb_result got hi=%h lo=%h want hi=%h lo=%h", hi, lo, sb_exp[63:32], sb_exp[31:0]);
        end
      end
    end
  end
  function automatic logic [63:0] model(muldiv_op_t o, logic [31:0] x, logic [31:0] y, logic [31:0] ah, logic [31:0] al);
    logic sg;
    logic [63:0] p, acc;
    logic [31:0] q, r;
    sg = o inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB, OP_DIV};
    acc = {ah, al};
    p = sg ? 64'($signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y})) : {32'b0, x} * {32'b0, y};
    if (o == OP_DIV || o == OP_DIVU) begin
      if (y == 0) return {x, 32'hFFFFFFFF};
      if (sg && x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      if (sg) begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
      end else begin
        q = x / y;
        r = x % y;
      end
      return {r, q};
    end
    if (o == OP_MADD || o == OP_MADDU) return acc + p;
    if (o == OP_MSUB || o == OP_MSUBU) return acc - p;
    return p;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input muldiv_op_t o, input logic [31:0] x, y, ah, al, output int lat);
    op = o; a = x; b = y; acc_hi = ah; acc_lo = al; req = 1'b1;
    sb.push_back(model(o, x, y, ah, al));
    #1;
    stall_log[0] = stall;
    lat = 0;
    while (!done && lat < 60) begin
      tick;
      lat++;
      stall_log[lat] = stall;
    end
    tick;
    req = 1'b0;
  endtask
  task automatic test_reset;
    #2;
    checks++;
    if ({busy, done, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
    end
    tick;
    resetn = 1'b1;
    tick;
  endtask
  task automatic test_mult;
    int lat;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 0, 0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL mult_latency got %0d want 3", lat); end
    checks++;
    if ({stall_log[0], stall_log[1], stall_log[2], stall_log[3]} !== 4'b1110) begin
      errors++;
      $display("FAIL mult_stall got %b%b%b%b want 1110", stall_log[0], stall_log[1], stall_log[2], stall_log[3]);
    end
  endtask
  task automatic test_div;
    int lat;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, lat);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, lat);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL div_min_latency got %0d want 34", lat); end
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, 0, 0, lat);
  endtask
  task automatic test_div_zero;
    int lat;
    run_op(OP_DIVU, 32'h80000000, 32'd0, 0, 0, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL divu_zero_latency got %0d want 2", lat); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, 0, 0, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL div_zero_latency got %0d want 2", lat); end
  endtask
  task automatic test_acc;
    int lat;
    run_op(OP_MADD, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL madd_latency got %0d want 3", lat); end
    run_op(OP_MSUBU, 32'd1, 32'd1, 0, 0, lat);
    run_op(OP_MUL, 32'h10000, 32'h10000, 0, 0, lat);
    run_op(OP_MSUB, 32'hFFFFFFFE, 32'd3, 32'h0, 32'd5, lat);
    run_op(OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, lat);
  endtask
  task automatic test_random;
    int lat, want;
    muldiv_op_t o;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = muldiv_op_t'($urandom_range(0, 8));
      x = $urandom;
      y = (i % 7 == 3) ? 32'd0 : (i % 5 == 1) ? 32'($urandom_range(1, 9)) : $urandom;
      want = (o == OP_DIV || o == OP_DIVU) ? (y == 0 ? 2 : 34) : 3;
      run_op(o, x, y, $urandom, $urandom, lat);
      checks++;
      if (lat !== want) begin errors++; $display("FAIL rand_latency op=%0d got %0d want %0d", o, lat, want); end
    end
  endtask
  task automatic test_flush;
    int lat;
    run_op(OP_MUL, 32'h10000, 32'h10000, 0, 0, lat);
    op = OP_DIVU; a = 32'd100; b = 32'd3; req = 1'b1;
    for (int c = 1; c <= 10; c++) tick;
    flush = 1'b1;
    #1;
    checks++;
    if ({busy, stall} !== 2'b10) begin errors++; $display("FAIL flush_c10 got busy=%b stall=%b want busy=1 stall=0", busy, stall); end
    tick;
    flush = 1'b0;
    req = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    checks++;
    if ({hi, lo} !== 64'h00000001_00000000) begin errors++; $display("FAIL flush_hold got hi=%h lo=%h want 1/0", hi, lo); end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 0, 0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL flush_next_latency got %0d want 3", lat); end
    req = 1'b1; flush = 1'b1;
    tick;
    req = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_req_idle got busy=%b want 0", busy); end
  endtask
  task automatic test_back_to_back;
    int lat1, lat2, n0;
    n0 = ndone;
    run_op(OP_MULT, 32'd6, 32'hFFFFFFFF, 0, 0, lat1);
    run_op(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, lat2);
    repeat (4) tick;
    checks++;
    if (lat1 !== 3 || lat2 !== 3) begin errors++; $display("FAIL b2b_latency got %0d,%0d want 3,3", lat1, lat2); end
    checks++;
    if (ndone - n0 !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", ndone - n0); end
  endtask
  task automatic test_reset_mid;
    int n0;
    n0 = ndone;
    op = OP_DIV; a = 32'd1000; b = 32'd7; req = 1'b1;
    for (int c = 1; c <= 5; c++) tick;
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
    end
    req = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
    repeat (40) tick;
    checks++;
    if (ndone !== n0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_after got dones=%0d busy=%b want 0/0", ndone - n0, busy); end
  endtask
  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_acc;
    test_random;
    test_flush;
    test_back_to_back;
    test_reset_mid;
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_pending got %0d results left want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
